pwm_audio_mixer: RTL and testbench

Multi-channel successor to the single-tone PWM audio block.
- NUM_CH independently programmable square-wave tone generators, each with its own frequency divider, volume and enable.
- Channels are summed, scaled, and drive one PWM output pin.
- Sits in the user project area: clocked by the Wishbone clock, configured from IO/LA pins through a simple write strobe.

---
 rtl/pwm_audio_mixer_pkg.sv | 19 +
 rtl/pwm_audio_mixer_if.sv | 13 +
 rtl/pwm_audio_mixer_tone_channel.sv | 40 ++++
 rtl/pwm_audio_mixer.sv | 75 +++++++
 tb/tb_pwm_audio_mixer.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/pwm_audio_mixer_pkg.sv
// Shared widths and config struct for the multi-channel PWM audio mixer.
// Channel count and field widths are fixed here; PRESCALE is a top-level parameter.
package pwm_audio_pkg;
  localparam int NUM_CH       = 4;
  localparam int FREQ_W       = 8;
  localparam int VOL_W        = 4;
  localparam int PWM_W        = 8;
  localparam int PRESCALE_DEF = 256;

  localparam int CH_IDX_W = $clog2(NUM_CH);
  localparam int SUM_W    = VOL_W + CH_IDX_W;
  localparam int SHIFT    = PWM_W - SUM_W;

  typedef struct packed {
    logic [FREQ_W-1:0] freq;
    logic [VOL_W-1:0]  vol;
    logic              en;
  } ch_cfg_t;
endpackage

// File: rtl/pwm_audio_mixer_if.sv
// Channel configuration write port: one strobe carries index, divider, volume and enable.
interface pwm_audio_mixer_if;
  import pwm_audio_pkg::*;

  logic                cfg_we;
  logic [CH_IDX_W-1:0] cfg_ch;
  logic [FREQ_W-1:0]   cfg_freq;
  logic [VOL_W-1:0]    cfg_vol;
  logic                cfg_en;

  modport master (output cfg_we, cfg_ch, cfg_freq, cfg_vol, cfg_en);
  modport slave  (input  cfg_we, cfg_ch, cfg_freq, cfg_vol, cfg_en);
endinterface

// File: rtl/pwm_audio_mixer_tone_channel.sv
// One square-wave tone generator: divider on prescaler ticks, toggling phase gates the volume.
module tone_channel
  import pwm_audio_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_tick,
  input  logic             i_we,
  input  ch_cfg_t          i_cfg,
  output logic [VOL_W-1:0] o_contrib
);
  ch_cfg_t           r_cfg;
  logic [FREQ_W-1:0] r_div;
  logic              r_phase;

  // A write restarts the tone and takes priority over a coincident tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cfg   <= '0;
      r_div   <= '0;
      r_phase <= 1'b0;
    end else if (i_we) begin
      r_cfg   <= i_cfg;
      r_div   <= '0;
      r_phase <= 1'b0;
    end else if (!r_cfg.en || r_cfg.freq == '0) begin
      r_div   <= '0;
      r_phase <= 1'b0;
    end else if (i_tick) begin
      if (r_div == r_cfg.freq) begin
        r_div   <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_div   <= r_div + 1'b1;
      end
    end
  end

  assign o_contrib = r_phase ? r_cfg.vol : '0;
endmodule

// File: rtl/pwm_audio_mixer.sv
// NUM_CH tone channels summed into one PWM pin; duty is only latched at period wrap.
module pwm_audio_mixer
  import pwm_audio_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEF
) (
  input  logic               clk,
  input  logic               reset,
  pwm_audio_mixer_if.slave   cfg,
  output logic               pwm_out,
  output logic               sample_strobe,
  output logic               io_oeb_low
);
  localparam int PRE_W = $clog2(PRESCALE);

  logic [PRE_W-1:0]                   r_pre;
  logic                               w_tick;
  ch_cfg_t                            w_cfg;
  logic [NUM_CH-1:0]                  w_we;
  logic [NUM_CH-1:0][VOL_W-1:0]       w_contrib;
  logic [SUM_W-1:0]                   w_sum;
  logic [PWM_W-1:0]                   w_duty_next;
  logic [PWM_W-1:0]                   r_pwm_cnt;
  logic [PWM_W-1:0]                   r_duty;
  logic                               r_strobe;
  logic                               r_pwm_out;

  assign w_tick = (r_pre == PRE_W'(PRESCALE - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_pre <= '0;
    else       r_pre <= w_tick ? '0 : r_pre + 1'b1;
  end

  assign w_cfg = '{freq: cfg.cfg_freq, vol: cfg.cfg_vol, en: cfg.cfg_en};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_we[i] = cfg.cfg_we && (cfg.cfg_ch == CH_IDX_W'(i));

    tone_channel u_ch (
      .clk       (clk),
      .reset     (reset),
      .i_tick    (w_tick),
      .i_we      (w_we[i]),
      .i_cfg     (w_cfg),
      .o_contrib (w_contrib[i])
    );
  end

  // SUM_W is sized so the full-scale sum of every channel cannot overflow.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_CH; i++) w_sum = w_sum + SUM_W'(w_contrib[i]);
  end

  assign w_duty_next = PWM_W'(w_sum) << SHIFT;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pwm_cnt <= '0;
      r_duty    <= '0;
      r_strobe  <= 1'b0;
      r_pwm_out <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      r_strobe  <= (r_pwm_cnt == '1);
      if (r_pwm_cnt == '1) r_duty <= w_duty_next;
      r_pwm_out <= (r_pwm_cnt < r_duty);
    end
  end

  assign pwm_out       = r_pwm_out;
  assign sample_strobe = r_strobe;
  assign io_oeb_low    = 1'b0;
endmodule

// File: tb/tb_pwm_audio_mixer.sv
// Directed bench for pwm_audio_mixer at PRESCALE=4; cycle k counts posedges since reset release.
module tb_pwm_audio_mixer;
  import pwm_audio_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pwm_out, sample_strobe, io_oeb_low;
  int   total = 0;
  int   bad = 0;

  pwm_audio_mixer_if cfg_if ();

  pwm_audio_mixer #(.PRESCALE(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .cfg           (cfg_if),
    .pwm_out       (pwm_out),
    .sample_strobe (sample_strobe),
    .io_oeb_low    (io_oeb_low)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench on the release negedge (k=0).
  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic wr(input logic [CH_IDX_W-1:0] ch, input logic [FREQ_W-1:0] f,
                    input logic [VOL_W-1:0] v, input logic e);
    cfg_if.cfg_we   = 1'b1;
    cfg_if.cfg_ch   = ch;
    cfg_if.cfg_freq = f;
    cfg_if.cfg_vol  = v;
    cfg_if.cfg_en   = e;
    step(1);
    cfg_if.cfg_we   = 1'b0;
  endtask

  // Waits for a strobe, then counts pwm_out over the following full period.
  task automatic measure(input string tag, input int exp);
    int n = 0;
    int hi = 0;
    while (!sample_strobe && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (!sample_strobe) chk({tag, "_strobe_wait"}, 0, 1);
    else begin
      for (int i = 0; i < 256; i++) begin
        @(negedge clk);
        hi += int'(pwm_out);
      end
      chk(tag, hi, exp);
    end
  endtask

  initial begin
    int hi, strb, n, viol;
    cfg_if.cfg_we = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_freq = '0;
    cfg_if.cfg_vol = '0;  cfg_if.cfg_en = 1'b0;

    // Reset state and idle
    step(1);
    do_reset();
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_strobe", int'(sample_strobe), 0);
    chk("rst_oeb", int'(io_oeb_low), 0);
    step(100);
    reset = 1'b1;
    #1;
    chk("arst_pwm", int'(pwm_out), 0);
    chk("arst_strobe", int'(sample_strobe), 0);
    chk("arst_cnt", int'(dut.r_pwm_cnt), 0);
    step(2);
    reset = 1'b0;
    hi = 0; strb = 0;
    for (int i = 0; i < 2560; i++) begin
      @(negedge clk);
      hi += int'(pwm_out);
      strb += int'(sample_strobe);
    end
    chk("idle_hi", hi, 0);
    chk("idle_strobes", strb, 10);
    chk("idle_oeb", int'(io_oeb_low), 0);

    // Single tone: write at k=1, phase toggles at k=16, 32, ...
    do_reset();
    wr(2'd0, 8'd3, 4'd15, 1'b1);
    n = 0;
    while (dut.g_ch[0].u_ch.r_phase != 1'b1 && n < 100) begin step(1); n++; end
    chk("tone_first_toggle", n, 15);
    n = 0;
    while (dut.g_ch[0].u_ch.r_phase != 1'b0 && n < 100) begin step(1); n++; end
    chk("tone_interval", n, 16);
    measure("tone_hi_p1", 60);
    measure("tone_hi_p2", 60);

    // Full mix: ch0 written on a tick edge (k=4), ch1..3 at k=5..7, all aligned
    do_reset();
    step(3);
    for (int c = 0; c < NUM_CH; c++) wr(CH_IDX_W'(c), 8'd1, 4'd15, 1'b1);
    measure("mix_hi_p1", 240);
    measure("mix_hi_p2", 240);

    // Silence: freq=0 and en=0 channels never toggle
    do_reset();
    wr(2'd2, 8'd0, 4'd15, 1'b1);
    wr(2'd1, 8'd5, 4'd15, 1'b0);
    viol = 0; hi = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (dut.g_ch[1].u_ch.r_phase || dut.g_ch[2].u_ch.r_phase) viol++;
      if (dut.w_contrib[1] != 4'd0 || dut.w_contrib[2] != 4'd0) viol++;
      hi += int'(pwm_out);
    end
    chk("silence_viol", viol, 0);
    chk("silence_hi", hi, 0);

    // Write/tick collision at k=8: ch0 rewritten, ch1 toggles on the same tick
    do_reset();
    wr(2'd1, 8'd1, 4'd15, 1'b1);
    wr(2'd0, 8'd1, 4'd15, 1'b1);
    step(5);
    wr(2'd0, 8'd2, 4'd15, 1'b1);
    chk("coll_ch0_div", int'(dut.g_ch[0].u_ch.r_div), 0);
    chk("coll_ch0_phase", int'(dut.g_ch[0].u_ch.r_phase), 0);
    chk("coll_ch1_phase", int'(dut.g_ch[1].u_ch.r_phase), 1);
    chk("coll_ch1_div", int'(dut.g_ch[1].u_ch.r_div), 0);

    // Glitch-free duty: phase high from k=1024; rewrite at k=1380 (pwm_cnt=100)
    do_reset();
    wr(2'd0, 8'd255, 4'd15, 1'b1);
    step(1279);
    chk("glitch_strobe_1280", int'(sample_strobe), 1);
    hi = 0; n = 0; strb = 0;
    for (int k = 1281; k <= 1792; k++) begin
      @(negedge clk);
      if (k <= 1536) hi += int'(pwm_out);
      else n += int'(pwm_out);
      strb += int'(sample_strobe);
      if (k == 1379) begin
        cfg_if.cfg_we = 1'b1; cfg_if.cfg_ch = 2'd0; cfg_if.cfg_freq = 8'd31;
        cfg_if.cfg_vol = 4'd3; cfg_if.cfg_en = 1'b1;
      end
      if (k == 1380) cfg_if.cfg_we = 1'b0;
    end
    chk("glitch_old_duty", hi, 60);
    chk("glitch_new_duty", n, 12);
    chk("glitch_strobes", strb, 2);
    step(3);
    chk("pre_arst_pwm", int'(pwm_out), 1);
    reset = 1'b1;
    #1;
    chk("arst_active_pwm", int'(pwm_out), 0);
    chk("arst_active_duty", int'(dut.r_duty), 0);
    step(2);
    reset = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
